// File: rtl/ahb_lite_wait_state_sram_slave.sv
// rtl/ahb_lite_wait_state_sram_slave.sv - AHB-Lite word SRAM responder with wait states and two-cycle ERROR
//
// Ports:
//   HCLK       in   1   clock
//   HRESET     in   1   synchronous, active-high reset
//   HSEL       in   1   slave select
//   HADDR      in   32  address (bits above ADDR_WIDTH ignored)
//   HTRANS     in   2   IDLE/BUSY/NONSEQ/SEQ
//   HWRITE     in   1   1 = write
//   HSIZE      in   3   0 byte, 1 half, 2 word
//   HWDATA     in   32  write data (data phase)
//   HREADY     in   1   bus ready
//   HREADYOUT  out  1   slave ready
//   HRESP      out  2   00 OKAY, 01 ERROR
//   HRDATA     out  32  read data, zero outside a final read cycle
//   HRUSER     out  32  completed-transfer count
module ahb_lite_wait_state_sram_slave #(
   parameter int ADDR_WIDTH  = 16,
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA,
   output logic [31:0] HRUSER
);

   localparam int IDX_W = $clog2(MEM_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LAST,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [2:0]       wait_cnt;
   logic [2:0]       wait_cnt_nxt;
   logic             bus_ready;
   logic             accept;
   logic             addr_err;
   logic [3:0]       lane_mask;
   logic [31:0]      word_idx;
   logic [IDX_W-1:0] dp_idx;
   logic             dp_write;
   logic [3:0]       dp_mask;
   logic             zw_pending;
   logic             okay_final;
   logic             done;
   logic [31:0]      xfer_count;
   logic [31:0]      mem [MEM_WORDS];
   logic             unused_bits;

   assign unused_bits = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};

   assign word_idx = 32'(HADDR[ADDR_WIDTH-1:2]);

   always_comb begin
      addr_err = (word_idx >= 32'(MEM_WORDS));
      case (HSIZE)
         3'd0:    ;
         3'd1:    if (HADDR[0]) addr_err = 1'b1;
         3'd2:    if (HADDR[1:0] != 2'b00) addr_err = 1'b1;
         default: addr_err = 1'b1;
      endcase
   end

   always_comb begin
      case (HSIZE)
         3'd0:    lane_mask = 4'b0001 << HADDR[1:0];
         3'd1:    lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   end

   // A new address phase is only taken while this slave is showing ready.
   assign bus_ready = (state == S_IDLE) || (state == S_LAST) || (state == S_ERR2);
   assign accept    = bus_ready && HSEL && HREADY && HTRANS[1];

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      HREADYOUT    = bus_ready;
      HRESP        = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;
      case (state)
         S_WAIT: begin
            if (wait_cnt == 3'd1) begin
               state_nxt = S_LAST;
            end else begin
               wait_cnt_nxt = wait_cnt - 3'd1;
            end
         end
         S_ERR1: state_nxt = S_ERR2;
         default: begin
            if (accept) begin
               if (addr_err) begin
                  state_nxt = S_ERR1;
               end else if (WAIT_STATES == 0) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt    = S_WAIT;
                  wait_cnt_nxt = 3'(WAIT_STATES);
               end
            end else begin
               state_nxt = S_IDLE;
            end
         end
      endcase
   end

   // With zero wait states the single data-phase cycle sits in IDLE, so a
   // flag marks that IDLE cycle as the end of an OKAY transfer.
   assign okay_final = (state == S_LAST) || ((state == S_IDLE) && zw_pending);
   assign done       = okay_final || (state == S_ERR2);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state      <= S_IDLE;
         wait_cnt   <= 3'd0;
         zw_pending <= 1'b0;
         dp_idx     <= '0;
         dp_write   <= 1'b0;
         dp_mask    <= 4'b0000;
         xfer_count <= 32'd0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_cnt_nxt;
         zw_pending <= accept && !addr_err && (WAIT_STATES == 0);
         if (accept) begin
            dp_idx   <= HADDR[IDX_W+1:2];
            dp_write <= HWRITE;
            dp_mask  <= lane_mask;
         end
         if (done) begin
            xfer_count <= xfer_count + 32'd1;
         end
      end
   end

   // Writes land on the edge closing the final data cycle; the read port is
   // combinational, so a read pipelined right behind a write to the same word
   // sees the byte-merged result with no extra bypass path.
   always_ff @(posedge HCLK) begin
      if (!HRESET && okay_final && dp_write) begin
         for (int b = 0; b < 4; b++) begin
            if (dp_mask[b]) begin
               mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
         end
      end
   end

   assign HRDATA = (okay_final && !dp_write) ? mem[dp_idx] : 32'd0;
   assign HRUSER = xfer_count;

endmodule

// File: tb/tb_ahb_lite_wait_state_sram_slave.sv
// tb/tb_ahb_lite_wait_state_sram_slave.sv - directed bench for ahb_lite_wait_state_sram_slave (WAIT_STATES 2 and 0)
module tb_ahb_lite_wait_state_sram_slave;

   typedef struct packed {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } op_t;

   logic        HCLK = 1'b0;
   logic        rst     [2];
   logic        sel     [2];
   logic [31:0] addr    [2];
   logic [1:0]  trans   [2];
   logic        wr      [2];
   logic [2:0]  size    [2];
   logic [31:0] wdata   [2];
   logic        rdy_o   [2];
   logic [1:0]  resp_o  [2];
   logic [31:0] rdata_o [2];
   logic [31:0] user_o  [2];

   always #5 HCLK = ~HCLK;

   ahb_lite_wait_state_sram_slave #(.ADDR_WIDTH(16), .MEM_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
      .HCLK(HCLK), .HRESET(rst[0]), .HSEL(sel[0]), .HADDR(addr[0]), .HTRANS(trans[0]),
      .HWRITE(wr[0]), .HSIZE(size[0]), .HWDATA(wdata[0]), .HREADY(rdy_o[0]),
      .HREADYOUT(rdy_o[0]), .HRESP(resp_o[0]), .HRDATA(rdata_o[0]), .HRUSER(user_o[0])
   );

   ahb_lite_wait_state_sram_slave #(.ADDR_WIDTH(16), .MEM_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
      .HCLK(HCLK), .HRESET(rst[1]), .HSEL(sel[1]), .HADDR(addr[1]), .HTRANS(trans[1]),
      .HWRITE(wr[1]), .HSIZE(size[1]), .HWDATA(wdata[1]), .HREADY(rdy_o[1]),
      .HREADYOUT(rdy_o[1]), .HRESP(resp_o[1]), .HRDATA(rdata_o[1]), .HRUSER(user_o[1])
   );

   // ---------------- behavioural model ----------------
   // Each accepted transfer owns a data phase lasting WAIT_STATES+1 cycles
   // (OKAY) or 2 cycles (ERROR); ph_left counts the cycles still to show.
   int          ph_left [2] = '{0, 0};
   logic        ph_err  [2] = '{1'b0, 1'b0};
   logic        ph_wr   [2] = '{1'b0, 1'b0};
   int          ph_idx  [2] = '{0, 0};
   logic [3:0]  ph_mask [2] = '{4'h0, 4'h0};
   logic [31:0] mcnt    [2] = '{32'd0, 32'd0};
   logic        preload [2] = '{1'b0, 1'b0};
   bit   [31:0] mmem    [2][1024];
   bit   [3:0]  mval    [2][1024];

   function automatic int ws_of(int i);
      return (i == 0) ? 2 : 0;
   endfunction

   always @(posedge HCLK) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            ph_left[i] = 0;
            mcnt[i]    = 32'd0;
         end else if (preload[i]) begin
            mcnt[i] = 32'hFFFF_FFFF;
         end else if (ph_left[i] > 1) begin
            ph_left[i] = ph_left[i] - 1;
         end else begin
            if (ph_left[i] == 1) begin
               mcnt[i] = mcnt[i] + 32'd1;
               if (!ph_err[i] && ph_wr[i]) begin
                  for (int b = 0; b < 4; b++) begin
                     if (ph_mask[i][b]) begin
                        mmem[i][ph_idx[i]][8*b +: 8] = wdata[i][8*b +: 8];
                        mval[i][ph_idx[i]][b] = 1'b1;
                     end
                  end
               end
            end
            if (sel[i] && trans[i][1]) begin
               int nbytes;
               int idx;
               logic bad;
               idx    = int'(addr[i][15:2]);
               nbytes = 1 << size[i];
               bad    = (idx >= 1024) || (size[i] > 3'd2) ||
                        ((int'(addr[i][1:0]) % nbytes) != 0);
               ph_err[i]  = bad;
               ph_wr[i]   = wr[i];
               ph_idx[i]  = idx;
               ph_mask[i] = 4'(((1 << nbytes) - 1) << addr[i][1:0]);
               ph_left[i] = bad ? 2 : ws_of(i) + 1;
            end else begin
               ph_left[i] = 0;
            end
         end
      end
   end

   // ---------------- checking ----------------
   int          n_cmp  = 0;
   int          n_fail = 0;
   int          stall   [2] = '{0, 0};
   int          ecnt    [2] = '{0, 0};
   logic [31:0] last_rd [2] = '{32'd0, 32'd0};

   task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d t=%0t got=%h want=%h", nm, i, $time, got, exp);
      end
   endtask

   task automatic compare(input int i);
      logic        fin_rd;
      logic [31:0] m;
      logic [31:0] ev;
      fin_rd = (ph_left[i] == 1) && !ph_err[i] && !ph_wr[i];
      chk("hreadyout", i, 32'(rdy_o[i]), 32'(ph_left[i] <= 1));
      chk("hresp", i, 32'(resp_o[i]), (ph_left[i] > 0 && ph_err[i]) ? 32'd1 : 32'd0);
      chk("hruser", i, user_o[i], mcnt[i]);
      m  = 32'hFFFF_FFFF;
      ev = 32'd0;
      if (fin_rd) begin
         ev = mmem[i][ph_idx[i]];
         for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{mval[i][ph_idx[i]][b]}};
         last_rd[i] = rdata_o[i];
      end
      chk("hrdata", i, rdata_o[i] & m, ev & m);
      if (!rdy_o[i]) stall[i]++;
      if (resp_o[i] == 2'b01) ecnt[i]++;
   endtask

   // ---------------- stimulus ----------------
   op_t  q    [2][$];
   op_t  dp   [2];
   logic dp_v [2] = '{1'b0, 1'b0};

   function automatic op_t mk(input logic s, input logic [1:0] t, input logic w,
                              input logic [31:0] a, input logic [2:0] z, input logic [31:0] d);
      op_t o;
      o.sel = s; o.trans = t; o.wr = w; o.addr = a; o.size = z; o.wdata = d;
      return o;
   endfunction

   function automatic op_t op_w(input logic [31:0] a, input logic [2:0] z, input logic [31:0] d);
      return mk(1'b1, 2'b10, 1'b1, a, z, d);
   endfunction

   function automatic op_t op_r(input logic [31:0] a, input logic [2:0] z);
      return mk(1'b1, 2'b10, 1'b0, a, z, 32'd0);
   endfunction

   task automatic drive(input int i);
      op_t ap;
      wdata[i] = dp_v[i] ? dp[i].wdata : 32'd0;
      ap = (q[i].size() > 0) ? q[i][0] : mk(1'b0, 2'b00, 1'b0, 32'd0, 3'd0, 32'd0);
      sel[i]   = ap.sel;
      trans[i] = ap.trans;
      wr[i]    = ap.wr;
      addr[i]  = ap.addr;
      size[i]  = ap.size;
      if (rdy_o[i] === 1'b1) begin
         if (q[i].size() > 0) void'(q[i].pop_front());
         dp[i]   = ap;
         dp_v[i] = ap.sel && ap.trans[1];
      end
   endtask

   task automatic tick();
      @(negedge HCLK);
      compare(0);
      compare(1);
      drive(0);
      drive(1);
   endtask

   task automatic run(input int i);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((q[i].size() > 0 || dp_v[i]) && n < 400);
      if (n >= 400) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout inst%0d t=%0t got=busy want=done", i, $time);
      end
      repeat (2) tick();
   endtask

   task automatic push_mixed(input int i);
      q[i].push_back(op_w(32'h40, 3'd1, 32'h0000_BEEF));
      q[i].push_back(op_w(32'h42, 3'd1, 32'hCAFE_0000));
      q[i].push_back(op_r(32'h40, 3'd2));
      q[i].push_back(op_w(32'h41, 3'd1, 32'h1111_1111));
      q[i].push_back(op_r(32'h40, 3'd3));
      q[i].push_back(op_w(32'h45, 3'd0, 32'h0000_AA00));
      q[i].push_back(op_r(32'h44, 3'd2));
      q[i].push_back(op_r(32'hFFFC, 3'd2));
      q[i].push_back(op_w(32'h0FFC, 3'd2, 32'h5A5A_5A5A));
      q[i].push_back(op_r(32'h0FFC, 3'd2));
      q[i].push_back(op_w(32'h47, 3'd0, 32'h7700_0000));
      q[i].push_back(op_r(32'h44, 3'd0));
      q[i].push_back(op_r(32'h1234_0040, 3'd2));
      q[i].push_back(op_r(32'h42, 3'd1));
   endtask

   logic [31:0] u0;

   initial begin
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      drive(0);
      drive(1);
      repeat (2) tick();
      chk("reset_hreadyout", 0, 32'(rdy_o[0]), 32'd1);
      chk("reset_hruser", 1, user_o[1], 32'd0);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      tick();

      // 1: WAIT_STATES=2 word write then read
      stall[0] = 0;
      q[0].push_back(op_w(32'h10, 3'd2, 32'hA5A5_1234));
      q[0].push_back(op_r(32'h10, 3'd2));
      run(0);
      chk("t1_rdata", 0, last_rd[0], 32'hA5A5_1234);
      chk("t1_stalls", 0, 32'(stall[0]), 32'd4);

      // 2: WAIT_STATES=0 byte write forwarded into pipelined read
      stall[1] = 0;
      u0 = user_o[1];
      q[1].push_back(op_w(32'h13, 3'd0, 32'h1200_0000));
      q[1].push_back(op_r(32'h10, 3'd2));
      run(1);
      chk("t2_rdata_b3", 1, {24'd0, last_rd[1][31:24]}, 32'h12);
      chk("t2_stalls", 1, 32'(stall[1]), 32'd0);
      chk("t2_hruser_delta", 1, user_o[1] - u0, 32'd2);

      // 3: out-of-range read and misaligned word write are ERRORs, no write
      ecnt[1] = 0;
      q[1].push_back(op_w(32'h0, 3'd2, 32'hCAFE_F00D));
      q[1].push_back(op_r(32'h1000, 3'd2));
      q[1].push_back(op_w(32'h2, 3'd2, 32'hDEAD_BEEF));
      q[1].push_back(op_r(32'h0, 3'd2));
      run(1);
      chk("t3_err_cycles", 1, 32'(ecnt[1]), 32'd4);
      chk("t3_mem_kept", 1, last_rd[1], 32'hCAFE_F00D);

      // mixed lanes, sizes and boundaries on both latencies
      push_mixed(0);
      run(0);
      chk("mix_rdata", 0, last_rd[0], 32'hCAFE_BEEF);
      push_mixed(1);
      run(1);
      chk("mix_rdata", 1, last_rd[1], 32'hCAFE_BEEF);

      // 4: IDLE / BUSY / deselected never start a transfer
      stall[0] = 0;
      u0 = user_o[0];
      q[0].push_back(mk(1'b1, 2'b00, 1'b0, 32'h80, 3'd2, 32'd0));
      q[0].push_back(mk(1'b1, 2'b01, 1'b1, 32'h80, 3'd2, 32'd0));
      q[0].push_back(mk(1'b1, 2'b00, 1'b1, 32'h80, 3'd2, 32'd0));
      q[0].push_back(mk(1'b0, 2'b10, 1'b1, 32'h80, 3'd2, 32'd0));
      q[0].push_back(mk(1'b1, 2'b01, 1'b0, 32'h80, 3'd2, 32'd0));
      run(0);
      chk("t4_stalls", 0, 32'(stall[0]), 32'd0);
      chk("t4_hruser_delta", 0, user_o[0] - u0, 32'd0);
      q[0].push_back(op_w(32'h80, 3'd2, 32'h0102_0304));
      q[0].push_back(mk(1'b1, 2'b01, 1'b0, 32'h84, 3'd2, 32'd0));
      q[0].push_back(mk(1'b1, 2'b01, 1'b0, 32'h84, 3'd2, 32'd0));
      q[0].push_back(op_r(32'h80, 3'd2));
      run(0);
      chk("t4_rdata", 0, last_rd[0], 32'h0102_0304);

      // 5: reset in the first wait cycle drops the pending write
      q[0].push_back(op_w(32'h20, 3'd2, 32'h1111_1111));
      run(0);
      q[0].push_back(op_w(32'h20, 3'd2, 32'h2222_2222));
      begin
         int n;
         n = 0;
         do begin
            tick();
            n++;
         end while (!dp_v[0] && n < 20);
      end
      tick();
      rst[0]  = 1'b1;
      dp_v[0] = 1'b0;
      tick();
      chk("t5_hreadyout", 0, 32'(rdy_o[0]), 32'd1);
      chk("t5_hruser", 0, user_o[0], 32'd0);
      rst[0] = 1'b0;
      q[0].push_back(op_r(32'h20, 3'd2));
      run(0);
      chk("t5_old_word", 0, last_rd[0], 32'h1111_1111);

      // 6: counter wrap
      force u_ws2.xfer_count = 32'hFFFF_FFFF;
      preload[0] = 1'b1;
      tick();
      release u_ws2.xfer_count;
      preload[0] = 1'b0;
      tick();
      chk("t6_preload", 0, user_o[0], 32'hFFFF_FFFF);
      q[0].push_back(op_r(32'h10, 3'd2));
      run(0);
      chk("t6_wrap", 0, user_o[0], 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
